// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: datapath widths, FSM encodings and frame constants.

`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef HBIT_ADDR
`define HBIT_ADDR 23
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

package imem_loader_pkg;

  // Every multi-byte field (address, count, data word) is three bytes, little-endian.
  localparam int unsigned BytesPerWord = 3;

  // FSM encodings, kept as plain constants so older blocks can share them.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StLen  = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StCsum = 3'd4;
  localparam logic [2:0] StDone = 3'd5;
  localparam logic [2:0] StErr  = 3'd6;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian 3-byte fields from a byte stream.
// ow_last flags the byte that completes a field; ow_word is the completed field in that cycle.

module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_clr,
  input  logic                iw_byte_valid,
  input  logic [7:0]          iw_byte,
  output logic                ow_last,
  output logic [`HBIT_DATA:0] ow_word
);

  localparam logic [1:0] LastIdx = 2'(BytesPerWord - 1);

  logic [1:0]          idx_q;
  logic [`HBIT_DATA:0] sr_q;

  // Newest byte enters at the top, so after three bytes the first one sits in the LSBs.
  assign ow_word = {iw_byte, sr_q[`HBIT_DATA:8]};
  assign ow_last = iw_byte_valid && (idx_q == LastIdx);

  // Byte index and shift register advance on every field byte.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      idx_q <= 2'd0;
      sr_q  <= '0;
    end else if (iw_clr) begin
      idx_q <= 2'd0;
    end else if (iw_byte_valid) begin
      idx_q <= ow_last ? 2'd0 : idx_q + 2'd1;
      sr_q  <= ow_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses SYNC/address/count/words/checksum frames,
// writes each word into imem and holds the core in reset while a frame is in flight.

`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef HBIT_ADDR
`define HBIT_ADDR 23
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_in_valid,
  input  logic [7:0]          iw_in_data,
  output logic                ow_in_ready,
  input  logic                iw_clr,
  output logic                ow_mem_we,
  output logic [`HBIT_ADDR:0] ow_mem_addr,
  output logic [`HBIT_DATA:0] ow_mem_wdata,
  output logic                ow_core_rst,
  output logic                ow_done,
  output logic                ow_error
);

  logic [2:0]          state_q, state_d;
  logic                mem_we_q;
  logic [`HBIT_ADDR:0] mem_addr_q;
  logic [`HBIT_DATA:0] mem_wdata_q;
  logic [`HBIT_ADDR:0] next_addr_q;
  logic [`HBIT_ADDR:0] remain_q;
  logic [7:0]          csum_q;

  logic                accept;
  logic                field_byte;
  logic                word_last;
  logic [`HBIT_DATA:0] word;

  // Ready in the parsing states, but not while a word is being written.
  assign ow_in_ready = (state_q == StIdle || state_q == StAddr || state_q == StLen ||
                        state_q == StData || state_q == StCsum) && !mem_we_q;
  assign accept      = iw_in_valid && ow_in_ready;
  assign field_byte  = accept && (state_q == StAddr || state_q == StLen || state_q == StData);

  byte_packer u_byte_packer (
    .iw_clk        (iw_clk),
    .iw_rst_n      (iw_rst_n),
    .iw_clr        (state_q == StIdle),
    .iw_byte_valid (field_byte),
    .iw_byte       (iw_in_data),
    .ow_last       (word_last),
    .ow_word       (word)
  );

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept && iw_in_data == SYNC) state_d = StAddr;
      StAddr: if (word_last) state_d = StLen;
      StLen:  if (word_last) state_d = (word == '0) ? StCsum : StData;
      StData: if (word_last && remain_q == `SIZE_ADDR'(1)) state_d = StCsum;
      StCsum: if (accept) state_d = (iw_in_data == csum_q) ? StDone : StErr;
      StDone: state_d = StIdle;
      StErr:  if (iw_clr) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Header capture, running checksum, word count and the registered write port.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      next_addr_q <= '0;
      remain_q    <= '0;
      csum_q      <= 8'h00;
    end else begin
      mem_we_q <= 1'b0;
      // Any byte accepted in IDLE restarts the checksum; only SYNC leaves IDLE anyway.
      if (state_q == StIdle && accept) begin
        csum_q <= 8'h00;
      end else if (field_byte) begin
        csum_q <= csum_q ^ iw_in_data;
      end
      if (state_q == StAddr && word_last) begin
        next_addr_q <= word;
      end
      if (state_q == StLen && word_last) begin
        remain_q <= word;
      end
      if (state_q == StData && word_last) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= next_addr_q;
        mem_wdata_q <= word;
        next_addr_q <= next_addr_q + `SIZE_ADDR'(1);
        remain_q    <= remain_q - `SIZE_ADDR'(1);
      end
    end
  end

  assign ow_mem_we    = mem_we_q;
  assign ow_mem_addr  = mem_addr_q;
  assign ow_mem_wdata = mem_wdata_q;
  assign ow_core_rst  = (state_q != StIdle);
  assign ow_done      = (state_q == StDone);
  assign ow_error     = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames built by a byte-level model, writes scoreboarded.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clr = 1'b0;
  logic        in_ready, mem_we, core_rst, done, error;
  logic [23:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.SYNC(8'hA5)) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_in_valid  (in_valid),
    .iw_in_data   (in_data),
    .ow_in_ready  (in_ready),
    .iw_clr       (clr),
    .ow_mem_we    (mem_we),
    .ow_mem_addr  (mem_addr),
    .ow_mem_wdata (mem_wdata),
    .ow_core_rst  (core_rst),
    .ow_done      (done),
    .ow_error     (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] got_q[$];    // {addr, data} observed on the write port
  logic [47:0] exp_q[$];    // {addr, data} predicted by the model
  logic [7:0]  frame_q[$];  // bytes of the frame to send
  logic [23:0] words_q[$];  // fixed payload words; random ones are used beyond its end
  int          done_cnt = 0;
  int          we_rdy_cnt = 0;
  int          cr_low_cnt = 0;
  bit          in_frame = 1'b0;
  bit          gaps = 1'b0;
  bit          clr_noise = 1'b0;

  // Monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
    if (mem_we && in_ready) we_rdy_cnt++;
    if (in_frame && !core_rst) cr_low_cnt++;
  end

  // Reference model: frame = SYNC, addr(3 LE), N(3 LE), N words(3 LE), XOR of bytes after SYNC.
  task automatic build_frame(input logic [23:0] addr, input int n, input bit bad_csum);
    logic [7:0]  cs;
    logic [23:0] w;
    logic [23:0] nn;
    frame_q.delete();
    exp_q.delete();
    nn = 24'(n);
    frame_q.push_back(8'hA5);
    for (int k = 0; k < 3; k++) frame_q.push_back(addr[8*k +: 8]);
    for (int k = 0; k < 3; k++) frame_q.push_back(nn[8*k +: 8]);
    for (int i = 0; i < n; i++) begin
      w = (i < words_q.size()) ? words_q[i] : 24'($urandom);
      for (int k = 0; k < 3; k++) frame_q.push_back(w[8*k +: 8]);
      exp_q.push_back({24'((int'(addr) + i) % (1 << 24)), w});
    end
    cs = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) cs ^= frame_q[i];
    if (bad_csum) cs ^= 8'($urandom_range(1, 255));
    frame_q.push_back(cs);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    if (clr_noise) clr = ($urandom_range(0, 3) == 0);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 40) begin
      n_bad++;
      $display("FAIL send_byte_ready: in_ready=%b required 1 within 40 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = 1'b0;
  endtask

  // Sends frame_q and checks writes, done/error, ready during writes and core reset.
  task automatic run_frame(input string name, input bit exp_err);
    int base_w, base_d, base_wr, base_cr, t;
    base_w  = got_q.size();
    base_d  = done_cnt;
    base_wr = we_rdy_cnt;
    base_cr = cr_low_cnt;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      if (i == 0) in_frame = 1'b1;
    end
    t = 0;
    while (!done && !error && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_frame = 1'b0;
    n_cmp++;
    if (t >= 50) begin
      n_bad++;
      $display("FAIL %s end_timeout: done=%b error=%b required one of them high", name, done,
               error);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_q.size() - base_w !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d required %0d", name, got_q.size() - base_w,
               exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (base_w + i >= got_q.size() || got_q[base_w + i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s write[%0d]: got %h required %h", name, i,
                 (base_w + i < got_q.size()) ? got_q[base_w + i] : 48'hx, exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt - base_d !== (exp_err ? 0 : 1)) begin
      n_bad++;
      $display("FAIL %s done_pulses: got %0d required %0d", name, done_cnt - base_d,
               exp_err ? 0 : 1);
    end
    n_cmp++;
    if (error !== exp_err) begin
      n_bad++;
      $display("FAIL %s error: got %b required %b", name, error, exp_err);
    end
    n_cmp++;
    if (we_rdy_cnt - base_wr !== 0) begin
      n_bad++;
      $display("FAIL %s ready_in_write_cycle: got %0d cycles required 0", name,
               we_rdy_cnt - base_wr);
    end
    n_cmp++;
    if (cr_low_cnt - base_cr !== 0) begin
      n_bad++;
      $display("FAIL %s core_rst_low_in_frame: got %0d cycles required 0", name,
               cr_low_cnt - base_cr);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, core_rst, done, error} !== 52'h0) begin
      n_bad++;
      $display("FAIL %s outputs: we=%b addr=%h wdata=%h core_rst=%b done=%b error=%b required 0",
               name, mem_we, mem_addr, mem_wdata, core_rst, done, error);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    words_q = '{24'h332211, 24'h665544};
    build_frame(24'h000100, 2, 1'b0);
    exp_q = '{{24'h000100, 24'h332211}, {24'h000101, 24'h665544}};
    n_cmp++;
    if (frame_q[frame_q.size() - 1] !== 8'h74) begin
      n_bad++;
      $display("FAIL basic_model_csum: got %h required 74", frame_q[frame_q.size() - 1]);
    end
    run_frame("basic", 1'b0);
  endtask

  task automatic test_wrap();
    words_q.delete();
    build_frame(24'hFFFFFF, 2, 1'b0);
    exp_q[0][47:24] = 24'hFFFFFF;
    exp_q[1][47:24] = 24'h000000;
    run_frame("wrap", 1'b0);
  endtask

  task automatic test_zero_len();
    words_q.delete();
    build_frame(24'($urandom), 0, 1'b0);
    run_frame("zero_len", 1'b0);
  endtask

  task automatic test_bad_csum();
    int viol;
    words_q.delete();
    build_frame(24'($urandom), 1, 1'b1);
    run_frame("bad_csum", 1'b1);
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (!error || in_ready || !core_rst) viol++;
    end
    n_cmp++;
    if (viol !== 0) begin
      n_bad++;
      $display("FAIL bad_csum_sticky: got %0d bad cycles required 0", viol);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_cmp++;
    if ({error, in_ready, core_rst} !== 3'b010) begin
      n_bad++;
      $display("FAIL bad_csum_clr: error/ready/core_rst got %b required 010",
               {error, in_ready, core_rst});
    end
  endtask

  task automatic test_leading_junk();
    words_q.delete();
    gaps = 1'b1;
    send_byte(8'h00);
    send_byte(8'h7F);
    repeat (3) send_byte(8'($urandom_range(0, 8'hA4)));
    build_frame(24'($urandom), 3, 1'b0);
    run_frame("leading_junk", 1'b0);
    gaps = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int base_w;
    words_q.delete();
    build_frame(24'($urandom), 2, 1'b0);
    base_w = got_q.size();
    for (int i = 0; i < 9; i++) send_byte(frame_q[i]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_ready: got %b required 1", in_ready);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (got_q.size() !== base_w) begin
      n_bad++;
      $display("FAIL mid_reset_no_write: got %0d writes required 0", got_q.size() - base_w);
    end
    build_frame(24'($urandom), 2, 1'b0);
    run_frame("after_reset", 1'b0);
  endtask

  task automatic test_random_frames();
    logic [23:0] a;
    words_q.delete();
    gaps = 1'b1;
    clr_noise = 1'b1;
    for (int f = 0; f < 6; f++) begin
      a = (f % 2 == 0) ? 24'($urandom) : 24'hFFFFFD + 24'(f % 3);
      build_frame(a, $urandom_range(0, 4), 1'b0);
      run_frame($sformatf("random%0d", f), 1'b0);
    end
    gaps = 1'b0;
    clr_noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_bad_csum();
    test_leading_junk();
    test_reset_mid_frame();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter SYNC, default 8'hA5, meaning the frame start byte.
REQ-002 SHALL have port iw_clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iw_rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-004 SHALL have port iw_in_valid, input, 1, meaning a byte is offered.
REQ-005 SHALL have port iw_in_data, input, 8, meaning the offered byte.
REQ-006 SHALL have port ow_in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-007 SHALL have port iw_clr, input, 1, meaning clear error and return to IDLE.
REQ-008 SHALL have port ow_mem_we, output, 1, meaning instruction-memory write strobe for the imem write port.
REQ-009 SHALL have port ow_mem_addr, output, `SIZE_ADDR, meaning the write address.
REQ-010 SHALL have port ow_mem_wdata, output, `SIZE_DATA, meaning the write word.
REQ-011 SHALL have port ow_core_rst, output, 1, meaning hold the core in reset while loading.
REQ-012 SHALL have port ow_done, output, 1, meaning one-cycle pulse on a good frame.
REQ-013 SHALL have port ow_error, output, 1, meaning sticky checksum error.

Function
REQ-014 SHALL accept a byte only on a cycle with iw_in_valid and ow_in_ready both high.
REQ-015 SHALL use frame format SYNC, 3 address bytes, 3 count bytes N, N words of 3 bytes each, then 1 checksum byte; all multi-byte fields little-endian; `SIZE_DATA = `SIZE_ADDR = 24.
REQ-016 SHALL use states IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR.
REQ-017 In IDLE SHALL discard every non-SYNC byte; an accepted SYNC byte SHALL move the FSM to ADDR.
REQ-018 SHALL move from ADDR to LEN after the 3rd address byte.
REQ-019 After the 3rd count byte SHALL move from LEN to DATA if N != 0, else to CSUM.
REQ-020 SHALL move from DATA to CSUM after the 3rd byte of word N.
REQ-021 SHALL move from CSUM to DONE if the checksum byte equals the running checksum, else to ERR.
REQ-022 SHALL move from DONE to IDLE after exactly one cycle.
REQ-023 SHALL stay in ERR until iw_clr is high, then move to IDLE.
REQ-024 SHALL keep ow_in_ready high in IDLE, ADDR, LEN, DATA and CSUM, except during the write cycle (REQ-025); it SHALL be low in DONE and ERR.
REQ-025 SHALL assert ow_mem_we for exactly one cycle, the cycle after the 3rd byte of a word is accepted, with ow_mem_wdata holding the assembled word; ow_in_ready SHALL be low in that cycle.
REQ-026 SHALL write the first word to the header address; the address SHALL increment by 1 per word and wrap modulo 2^24.
REQ-027 SHALL compute the running checksum as the XOR of every byte after SYNC up to, but not including, the checksum byte.
REQ-028 SHALL drive ow_core_rst high from the cycle after SYNC is accepted until the FSM leaves DONE; ow_core_rst SHALL also stay high in ERR.
REQ-029 SHALL assert ow_done only in DONE.
REQ-030 SHALL assert ow_error only in ERR.
REQ-031 SHALL give iw_clr no effect outside ERR.

Reset
REQ-032 SHALL asynchronously force the following when iw_rst_n is low: state IDLE; ow_mem_we 0; ow_mem_addr 0; ow_mem_wdata 0; ow_core_rst 0; ow_done 0; ow_error 0; checksum 0; all counters 0.
REQ-033 SHALL abandon any frame in progress if reset is asserted mid-frame and perform no further writes; no partial word SHALL be written.
REQ-034 SHALL drive ow_in_ready high in the first cycle after iw_rst_n deasserts.

Structure
REQ-035 SHALL take the width macros `SIZE_ADDR, `SIZE_DATA, `HBIT_ADDR and `HBIT_DATA from the shared sizes header.
REQ-036 SHALL define the FSM state encodings and the byte-per-word constant (3) in a shared loader header.
REQ-037 SHALL place byte-to-word assembly (byte index 0..2 with shift register) in one sub-module, byte_packer.

Verification
REQ-038 Stimulus A5 00 01 00 02 00 00 11 22 33 44 55 66, checksum = XOR of those 12 bytes -> writes 0x332211 @0x000100 and 0x665544 @0x000101; ow_done pulses once; ow_core_rst high for the whole frame.
REQ-039 Stimulus A5 with address FFFFFF and N=2 -> writes land at 0xFFFFFF and then 0x000000.
REQ-040 Stimulus with N=0 and correct checksum -> no ow_mem_we; ow_done pulses; with a wrong checksum -> ow_error stays high and ow_in_ready low until iw_clr.
REQ-041 Stimulus 00 7F A5 ... preceding a frame -> the leading bytes are ignored and the frame loads correctly; random iw_in_valid gaps leave results unchanged.
REQ-042 Stimulus iw_rst_n low after the 2nd data byte -> no write, all outputs 0; a following full frame loads correctly.
